// File: rtl/modn_countdown_timer_pkg.sv
// ============================================================================
// modn_countdown_timer_pkg : shared widths, default M:SS moduli, digit helper
// Rev 1.0
// ============================================================================
`default_nettype none

package modn_countdown_timer_pkg;

  localparam int BCD_W = 4;

  // Default moduli for an M:SS cook timer: seconds ones, seconds tens, minutes.
  localparam logic [3*BCD_W-1:0] DEF_MODS = {4'd10, 4'd6, 4'd10};

  // Nibble i of a packed per-digit vector (up to four digits).
  function automatic int mod_of(input logic [4*BCD_W-1:0] v, input int i);
    return int'(v[BCD_W*i +: BCD_W]);
  endfunction

endpackage

`default_nettype wire

// File: rtl/modn_countdown_timer_digit.sv
// ============================================================================
// modn_digit : one modulo-MOD BCD digit with clamped load and up/down wrap
// Rev 1.0
// ============================================================================
`default_nettype none

module modn_digit
  import modn_countdown_timer_pkg::*;
#(
  parameter int MOD = 10
) (
  input  logic             clock,
  input  logic             clr,
  input  logic             load,
  input  logic [BCD_W-1:0] din,
  input  logic             cnt,
  input  logic             up,
  output logic [BCD_W-1:0] q,
  output logic             at_min,
  output logic             at_max
);

  localparam logic [BCD_W-1:0] c_MAX = BCD_W'(MOD - 1);
  localparam logic [BCD_W-1:0] c_MOD = BCD_W'(MOD);

  logic [BCD_W-1:0] r_q;
  logic [BCD_W-1:0] w_din_clamped;

  // Out-of-range load nibbles saturate to the digit's top value.
  assign w_din_clamped = (din >= c_MOD) ? c_MAX : din;

  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= w_din_clamped;
    end else if (cnt) begin
      if (up) begin
        r_q <= (r_q == c_MAX) ? '0 : r_q + 1'b1;
      end else begin
        r_q <= (r_q == '0) ? c_MAX : r_q - 1'b1;
      end
    end
  end

  assign q      = r_q;
  assign at_min = (r_q == '0);
  assign at_max = (r_q == c_MAX);

endmodule

`default_nettype wire

// File: rtl/modn_countdown_timer.sv
// ============================================================================
// modn_countdown_timer : cascaded mod-N BCD up/down counter with expiry pulse
// Rev 1.0
// ============================================================================
`default_nettype none

module modn_countdown_timer
  import modn_countdown_timer_pkg::*;
#(
  parameter int                     DIGITS = 3,
  parameter logic [4*DIGITS-1:0]    MODS   = DEF_MODS,
  parameter bit                     SAT    = 1'b1
) (
  input  logic                      clock,
  input  logic                      clr,
  input  logic                      loadn,
  input  logic                      en,
  input  logic                      up,
  input  logic [BCD_W*DIGITS-1:0]   data,
  output logic [BCD_W*DIGITS-1:0]   dout,
  output logic                      tc,
  output logic                      zero,
  output logic                      done
);

  localparam int                  c_DW  = BCD_W * DIGITS;
  localparam logic [c_DW-1:0]     c_ONE = c_DW'(1);

  logic [DIGITS-1:0] w_at_min;
  logic [DIGITS-1:0] w_at_max;
  logic [DIGITS-1:0] w_carry;
  logic [DIGITS-1:0] w_borrow;
  logic [DIGITS-1:0] w_dcnt;
  logic              w_all_max;
  logic              w_cnt_en;
  logic              w_expire;
  logic              r_done;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_digit
      // Digit g moves only when every lower digit is at its wrap point.
      if (g == 0) begin : g_lsd
        assign w_carry[g]  = 1'b1;
        assign w_borrow[g] = 1'b1;
      end else begin : g_upper
        assign w_carry[g]  = &w_at_max[g-1:0];
        assign w_borrow[g] = &w_at_min[g-1:0];
      end

      assign w_dcnt[g] = w_cnt_en & (up ? w_carry[g] : w_borrow[g]);

      modn_digit #(
        .MOD (mod_of(16'(MODS), g))
      ) u_digit (
        .clock  (clock),
        .clr    (clr),
        .load   (~loadn),
        .din    (data[BCD_W*g +: BCD_W]),
        .cnt    (w_dcnt[g]),
        .up     (up),
        .q      (dout[BCD_W*g +: BCD_W]),
        .at_min (w_at_min[g]),
        .at_max (w_at_max[g])
      );
    end
  endgenerate

  assign zero      = &w_at_min;
  assign w_all_max = &w_at_max;

  // Saturating timers freeze at zero instead of wrapping on a down count.
  assign w_cnt_en = en & ~(SAT & ~up & zero);

  assign tc = en & (up ? w_all_max : zero);

  // The only nonzero-to-zero down step is from exactly one.
  assign w_expire = loadn & en & ~up & (dout == c_ONE);

  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_expire;
    end
  end

  assign done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_modn_countdown_timer.sv
// ============================================================================
// tb_modn_countdown_timer : vector table + scoreboard bench for both SAT modes
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_modn_countdown_timer;

  logic        clock = 1'b0;
  logic        clr   = 1'b1;
  logic        loadn = 1'b1, en = 1'b0, up = 1'b0;
  logic [11:0] data  = '0;
  logic [11:0] dout;
  logic        tc, zero, done;

  logic        w_loadn = 1'b1, w_en = 1'b0, w_up = 1'b0;
  logic [11:0] w_data  = '0;
  logic [11:0] w_dout;
  logic        w_tc, w_zero, w_done;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    bit          sel;
    logic [11:0] xd;
    logic        xdone;
    string       nm;
  } exp_t;

  typedef struct {
    logic        ln, e, u;
    logic [11:0] d;
    logic [11:0] xd;
    logic        xdone;
    string       nm;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[18];

  always #5 clock = ~clock;

  modn_countdown_timer #(.DIGITS(3), .MODS({4'd10, 4'd6, 4'd10}), .SAT(1'b1)) dut (
    .clock(clock), .clr(clr), .loadn(loadn), .en(en), .up(up), .data(data),
    .dout(dout), .tc(tc), .zero(zero), .done(done)
  );

  modn_countdown_timer #(.DIGITS(3), .MODS({4'd10, 4'd6, 4'd10}), .SAT(1'b0)) dut_w (
    .clock(clock), .clr(clr), .loadn(w_loadn), .en(w_en), .up(w_up), .data(w_data),
    .dout(w_dout), .tc(w_tc), .zero(w_zero), .done(w_done)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [11:0] to_bcd(input int s);
    return {4'(s / 60), 4'((s % 60) / 10), 4'(s % 10)};
  endfunction

  // Drive one cycle of stimulus, queue its expectation, then score the result.
  task automatic step(input bit sel, input logic ln, input logic e, input logic u,
                      input logic [11:0] d, input logic [11:0] xd, input logic xdone,
                      input string nm);
    exp_t x;
    @(negedge clock);
    if (sel) begin
      w_loadn = ln; w_en = e; w_up = u; w_data = d;
      loadn = 1'b1; en = 1'b0;
    end else begin
      loadn = ln; en = e; up = u; data = d;
      w_loadn = 1'b1; w_en = 1'b0;
    end
    sb.push_back('{sel, xd, xdone, nm});
    @(posedge clock);
    #1;
    x = sb.pop_front();
    check({x.nm, ".dout"}, 32'(x.sel ? w_dout : dout), 32'(x.xd));
    check({x.nm, ".done"}, 32'(x.sel ? w_done : done), 32'(x.xdone));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    //        ln    e     u     data     dout     done  name
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 12'h959, 12'h959, 1'b0, "load959"};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 12'h100, 12'h100, 1'b0, "load100"};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 12'h000, 12'h059, 1'b0, "borrow"};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 12'h000, 12'h058, 1'b0, "dec"};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 12'h058, 12'h058, 1'b0, "load_over_en"};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 12'h000, 12'h059, 1'b0, "inc"};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 12'h000, 12'h100, 1'b0, "carry"};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 12'hFCF, 12'h959, 1'b0, "clamp"};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 1'b0, "load_zero"};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 12'h001, 12'h001, 1'b0, "load001"};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 12'h000, 12'h000, 1'b1, "expire"};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 12'h000, 12'h000, 1'b0, "saturate"};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 12'h959, 12'h959, 1'b0, "load_up959"};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 12'h000, 12'h000, 1'b0, "up_wrap"};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 12'h003, 12'h003, 1'b0, "prio_a"};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 12'h003, 12'h003, 1'b0, "prio_b"};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 12'h003, 12'h003, 1'b0, "prio_c"};
    tbl[17] = '{1'b1, 1'b0, 1'b0, 12'h000, 12'h003, 1'b0, "hold"};

    // Reset state, observed while clr is still asserted.
    #2;
    check("rst.dout", 32'(dout), 32'h000);
    check("rst.zero", 32'(zero), 32'h1);
    check("rst.done", 32'(done), 32'h0);
    @(negedge clock);
    clr = 1'b0;

    foreach (tbl[i])
      step(1'b0, tbl[i].ln, tbl[i].e, tbl[i].u, tbl[i].d, tbl[i].xd, tbl[i].xdone, tbl[i].nm);

    // Asynchronous clear in the middle of a cycle.
    step(1'b0, 1'b0, 1'b0, 1'b0, 12'h959, 12'h959, 1'b0, "pre_clr");
    @(negedge clock);
    loadn = 1'b1;
    #2 clr = 1'b1;
    #1;
    check("aclr.dout", 32'(dout), 32'h000);
    check("aclr.zero", 32'(zero), 32'h1);
    check("aclr.done", 32'(done), 32'h0);
    @(negedge clock);
    clr = 1'b0;

    // Full minute of down counting from 1:00, model tracks seconds left.
    step(1'b0, 1'b0, 1'b0, 1'b0, 12'h100, 12'h100, 1'b0, "long_load");
    for (int k = 1; k <= 60; k++)
      step(1'b0, 1'b1, 1'b1, 1'b0, 12'h000, to_bcd(60 - k), (k == 60), "long_down");
    #1;
    check("long.tc", 32'(tc), 32'h1);
    check("long.zero", 32'(zero), 32'h1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 12'h000, 1'b0, "long_sat");

    // Up-mode terminal count one step before wrap.
    step(1'b0, 1'b0, 1'b0, 1'b1, 12'h959, 12'h959, 1'b0, "tc_load");
    @(negedge clock);
    loadn = 1'b1; en = 1'b1; up = 1'b1;
    #1;
    check("up.tc", 32'(tc), 32'h1);
    @(posedge clock);
    #1;
    check("up.dout", 32'(dout), 32'h000);
    check("up.done", 32'(done), 32'h0);

    // One step before expiry, down-mode tc must still be low.
    step(1'b0, 1'b0, 1'b0, 1'b0, 12'h001, 12'h001, 1'b0, "exp_load");
    @(negedge clock);
    loadn = 1'b1; en = 1'b1; up = 1'b0;
    #1;
    check("pre.tc", 32'(tc), 32'h0);
    @(posedge clock);
    #1;
    check("exp.done", 32'(done), 32'h1);
    clr = 1'b1;
    #1;
    check("exp_clr.done", 32'(done), 32'h0);
    check("exp_clr.dout", 32'(dout), 32'h000);
    @(negedge clock);
    clr = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("after_clr.done", 32'(done), 32'h0);
    check("after_clr.dout", 32'(dout), 32'h000);

    // Wrapping variant: zero rolls to 9:59 instead of holding.
    step(1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 1'b0, "w_load0");
    step(1'b1, 1'b1, 1'b1, 1'b0, 12'h000, 12'h959, 1'b0, "w_wrap");
    step(1'b1, 1'b0, 1'b0, 1'b0, 12'h001, 12'h001, 1'b0, "w_load1");
    step(1'b1, 1'b1, 1'b1, 1'b0, 12'h000, 12'h000, 1'b1, "w_expire");
    step(1'b1, 1'b1, 1'b1, 1'b0, 12'h000, 12'h959, 1'b0, "w_wrap2");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
